sram_addr_gen: RTL and testbench
================================

Name: sram_addr_gen

Overview:
Pipelined, parametrised successor to the frame decoder's object-to-SRAM address encoder. It accepts (object ID, pixel index) requests over a valid/ready handshake. Each request is translated to a packed-word SRAM address using a per-object base/size table. The block also reports the pixel lane within the word, out-of-bounds requests, and repeated-word hits, so the SRAM reader can skip redundant reads. It sits between the frame decoder's pixel walker and the SRAM read controller.

Parameters:
- ADDR_W, 20, SRAM word address width.
- PIX_IDX_W, 19, pixel index width (map H+V width).
- OBJ_ID_W, 4, object ID width.
- NUM_OBJ, 10, number of valid table entries (IDs 0..NUM_OBJ-1).
- PPW_LOG2, 2, log2 of pixels per SRAM word (4 px/word).
- CNT_W, 16, read-counter width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid && o_ready
- i_object_id  in  OBJ_ID_W  object ID (game_pkg::ObjectID encoding)
- i_pixel_index  in  PIX_IDX_W  pixel index within the object
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts when o_valid && i_ready
- o_sram_addr  out  ADDR_W  word address
- o_lane  out  PPW_LOG2  pixel slot within the word
- o_oob  out  1  request out of bounds
- o_reuse  out  1  same word as the last issued read; the read may be skipped
- i_flush  in  1  frame boundary; clears reuse tracking and the counter
- o_read_cnt  out  CNT_W  count of real SRAM reads issued

Behaviour:
- Reset state:
  - o_valid=0, o_sram_addr=0, o_lane=0, o_oob=0, o_read_cnt=0.
  - Internal stage-1 valid=0, last_valid=0, last_addr=0.
  - o_reuse=0 (it is combinational from cleared registers).
  - o_ready=1 from the first cycle after reset.
- Pipeline has two register stages, so latency is 2 cycles from input handshake to o_valid when unstalled. Throughput is 1 request/cycle.
- Stage 1:
  - Registers the pixel index and the table lookup base=OBJ_BASE[id], size=OBJ_SIZE[id].
  - For id >= NUM_OBJ, an id_bad flag is registered instead.
- Stage 2:
  - o_sram_addr = (base + (idx >> PPW_LOG2)) mod 2^ADDR_W; the zero-extended sum wraps, with no saturation.
  - o_lane = idx[PPW_LOG2-1:0].
  - o_oob = id_bad || idx >= size.
  - When o_oob=1, o_sram_addr is forced to 0 and o_lane to 0.
- Stall rules:
  - en2 = !o_valid || i_ready.
  - en1 = !s1_valid || en2.
  - o_ready = en1. This is a combinational path from i_ready, accepted by the team.
- Outputs hold stable while o_valid && !i_ready. No bubbles are inserted and no requests are dropped.
- Reuse (combinational from registers): o_reuse = o_valid && last_valid && !o_oob && o_sram_addr==last_addr.
- On an output handshake with !o_oob:
  - last_addr <= o_sram_addr, last_valid <= 1.
  - If !o_reuse, o_read_cnt increments, saturating at 2^CNT_W-1.
- An OOB handshake changes neither last_addr nor the counter.
- i_flush:
  - Next cycle: last_valid=0, o_read_cnt=0.
  - It has priority over a simultaneous handshake update; that handshake is not counted.
  - The pipeline contents are unaffected.
- Asynchronous reset mid-transfer discards all in-flight requests immediately.

Decomposition:
- sram_pkg holds:
  - typed constant arrays OBJ_BASE[NUM_OBJ] and OBJ_SIZE[NUM_OBJ], replacing the per-object *_ADDR_START constants;
  - localparams PPW_LOG2 and ADDR_W defaults.
- game_pkg::ObjectID supplies the ID encoding.
- One natural sub-module: sram_read_counter (saturating counter with clear, used for o_read_cnt).

Test Plan:
- Reset, then id=OBJECT_MAP (base 0), idx=13, i_ready=1 → o_valid 2 cycles later; addr=3, lane=1, oob=0, reuse=0, read_cnt=1.
- Back-to-back idx 12,13,14,15,16 on the same object → addr 3,3,3,3,4; reuse 0,1,1,1,0; read_cnt=2. One result per cycle.
- Hold i_ready=0 for 5 cycles with 3 requests sent → o_ready drops after 2 accepted; outputs stay stable. On release, all results emerge in order with none lost.
- idx=OBJ_SIZE[id] and id=NUM_OBJ+1 → o_oob=1, addr=0, lane=0. read_cnt and last_addr are unchanged.
- Base=2^ADDR_W-1, idx=8 → addr=1, demonstrating wrap.
- i_flush asserted in the same cycle as a handshake on a repeated word → next request to that word gives reuse=0, and read_cnt counts from 0 then 1.
- Preload read_cnt to 2^CNT_W-1 → a further new-word read keeps it saturated.
- Assert i_rst_n low mid-stream → o_valid=0 asynchronously and all outputs return to their reset values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-object encoding used by the frame decoder and its SRAM address path.
package game_pkg;

    localparam int OBJ_ID_W = 4;

    typedef enum logic [OBJ_ID_W-1:0] {
        OBJECT_MAP     = 4'd0,
        OBJECT_PLAYER  = 4'd1,
        OBJECT_ENEMY   = 4'd2,
        OBJECT_BULLET  = 4'd3,
        OBJECT_WALL    = 4'd4,
        OBJECT_DOOR    = 4'd5,
        OBJECT_KEY     = 4'd6,
        OBJECT_HEART   = 4'd7,
        OBJECT_FONT    = 4'd8,
        OBJECT_SCRATCH = 4'd9
    } ObjectID;

endpackage

// File: rtl/sram_pkg.sv
// SRAM layout of the game objects: per-object base word and size in pixels,
// indexed by game_pkg::ObjectID, plus the default address-generator geometry.
package sram_pkg;

    localparam int SRAM_ADDR_W    = 20;
    localparam int SRAM_PIX_IDX_W = 19;
    localparam int SRAM_PPW_LOG2  = 2;
    localparam int SRAM_NUM_OBJ   = 10;

    typedef logic [SRAM_ADDR_W-1:0]    sram_addr_t;
    typedef logic [SRAM_PIX_IDX_W-1:0] pix_idx_t;

    // Objects are packed back to back after the 640x480 map; the scratch
    // object lives in the very last word so its reads wrap to the bottom.
    localparam sram_addr_t OBJ_BASE [SRAM_NUM_OBJ] = '{
        20'd0,      20'd76800,  20'd77056,  20'd77312,  20'd77328,
        20'd78352,  20'd78864,  20'd78928,  20'd78992,  20'hFFFFF
    };

    localparam pix_idx_t OBJ_SIZE [SRAM_NUM_OBJ] = '{
        19'd307200, 19'd1024,   19'd1024,   19'd64,     19'd4096,
        19'd2048,   19'd256,    19'd256,    19'd8192,   19'd64
    };

endpackage

// File: rtl/sram_read_counter.sv
// Saturating event counter with a synchronous clear that beats the increment.
module sram_read_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_count <= '0;
        end else if (i_clear) begin
            o_count <= '0;
        end else if (i_inc && (o_count != '1)) begin
            o_count <= o_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sram_addr_gen.sv
// Two-stage pipelined (object ID, pixel index) to packed SRAM word translator,
// reporting lane, out-of-bounds and repeated-word hits to the SRAM reader.
module sram_addr_gen
    import sram_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int PIX_IDX_W = SRAM_PIX_IDX_W,
    parameter int OBJ_ID_W  = game_pkg::OBJ_ID_W,
    parameter int NUM_OBJ   = SRAM_NUM_OBJ,
    parameter int PPW_LOG2  = SRAM_PPW_LOG2,
    parameter int CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [OBJ_ID_W-1:0]  i_object_id,
    input  logic [PIX_IDX_W-1:0] i_pixel_index,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [ADDR_W-1:0]    o_sram_addr,
    output logic [PPW_LOG2-1:0]  o_lane,
    output logic                 o_oob,
    output logic                 o_reuse,
    input  logic                 i_flush,
    output logic [CNT_W-1:0]     o_read_cnt
);

    logic                 s1_valid;
    logic                 s1_id_bad;
    logic [PIX_IDX_W-1:0] s1_idx;
    logic [PIX_IDX_W-1:0] s1_size;
    logic [ADDR_W-1:0]    s1_base;
    logic                 lkp_hit;
    logic [PIX_IDX_W-1:0] lkp_size;
    logic [ADDR_W-1:0]    lkp_base;
    logic                 s2_oob;
    logic [ADDR_W-1:0]    s2_addr;
    logic                 en1;
    logic                 en2;
    logic                 out_hs;
    logic                 last_valid;
    logic [ADDR_W-1:0]    last_addr;

    // Each stage advances when it is empty or the stage after it is moving.
    assign en2     = !o_valid || i_ready;
    assign en1     = !s1_valid || en2;
    assign o_ready = en1;
    assign out_hs  = o_valid && i_ready;

    always_comb begin
        lkp_hit  = 1'b0;
        lkp_base = '0;
        lkp_size = '0;
        for (int i = 0; i < SRAM_NUM_OBJ; i++) begin
            if ((i < NUM_OBJ) && (int'(i_object_id) == i)) begin
                lkp_hit  = 1'b1;
                lkp_base = ADDR_W'(OBJ_BASE[i]);
                lkp_size = PIX_IDX_W'(OBJ_SIZE[i]);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid  <= 1'b0;
            s1_id_bad <= 1'b0;
            s1_idx    <= '0;
            s1_size   <= '0;
            s1_base   <= '0;
        end else if (en1) begin
            s1_valid  <= i_valid;
            s1_id_bad <= !lkp_hit;
            s1_idx    <= i_pixel_index;
            s1_size   <= lkp_size;
            s1_base   <= lkp_base;
        end
    end

    // The word sum is allowed to wrap around the top of the SRAM.
    assign s2_oob  = s1_id_bad || (s1_idx >= s1_size);
    assign s2_addr = s1_base + ADDR_W'(s1_idx >> PPW_LOG2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid     <= 1'b0;
            o_oob       <= 1'b0;
            o_sram_addr <= '0;
            o_lane      <= '0;
        end else if (en2) begin
            o_valid     <= s1_valid;
            o_oob       <= s2_oob;
            o_sram_addr <= s2_oob ? '0 : s2_addr;
            o_lane      <= s2_oob ? '0 : s1_idx[PPW_LOG2-1:0];
        end
    end

    assign o_reuse = o_valid && last_valid && !o_oob && (o_sram_addr == last_addr);

    // A frame flush forgets the last word even if a result leaves this cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_valid <= 1'b0;
            last_addr  <= '0;
        end else if (i_flush) begin
            last_valid <= 1'b0;
        end else if (out_hs && !o_oob) begin
            last_valid <= 1'b1;
            last_addr  <= o_sram_addr;
        end
    end

    sram_read_counter #(
        .CNT_W (CNT_W)
    ) u_read_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_flush),
        .i_inc   (out_hs && !o_oob && !o_reuse),
        .o_count (o_read_cnt)
    );

endmodule

// File: tb/tb_sram_addr_gen.sv
// Self-checking bench for sram_addr_gen: directed scenarios plus randomized traffic,
// all compared every cycle against a queue-based model of in-flight requests.
module tb_sram_addr_gen;
    import game_pkg::*;
    import sram_pkg::*;

    localparam int TB_CNT_W = 5;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                i_clk = 1'b0;
    logic                i_rst_n;
    logic                i_valid;
    logic                o_ready;
    logic [3:0]          i_object_id;
    logic [18:0]         i_pixel_index;
    logic                o_valid;
    logic                i_ready;
    logic [19:0]         o_sram_addr;
    logic [1:0]          o_lane;
    logic                o_oob;
    logic                o_reuse;
    logic                i_flush;
    logic [TB_CNT_W-1:0] o_read_cnt;

    always #5 i_clk = ~i_clk;

    sram_addr_gen #(
        .CNT_W (TB_CNT_W)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_object_id   (i_object_id),
        .i_pixel_index (i_pixel_index),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_sram_addr   (o_sram_addr),
        .o_lane        (o_lane),
        .o_oob         (o_oob),
        .o_reuse       (o_reuse),
        .i_flush       (i_flush),
        .o_read_cnt    (o_read_cnt)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: what a request must produce, straight from the object table.
    typedef struct {
        logic [19:0] addr;
        logic [1:0]  lane;
        logic        oob;
        int          acc;
    } exp_t;

    function automatic exp_t modelResult(input int id, input int idx, input int acc);
        exp_t   r;
        longint word;
        r.acc  = acc;
        r.oob  = 1'b1;
        r.addr = '0;
        r.lane = '0;
        if (id < SRAM_NUM_OBJ) begin
            if (idx < int'(OBJ_SIZE[id])) begin
                word   = (longint'(OBJ_BASE[id]) + longint'(idx / 4)) % (longint'(1) << 20);
                r.oob  = 1'b0;
                r.addr = 20'(word);
                r.lane = 2'(idx % 4);
            end
        end
        return r;
    endfunction

    exp_t        exp_q[$];
    exp_t        front;
    int          cyc = 0;
    bit          exp_valid;
    bit          exp_ready;
    bit          exp_reuse;
    bit          out_hs;
    bit          in_hs;
    bit          m_last_valid;
    logic [19:0] m_last_addr;
    int          m_cnt;

    // Model state advances at each negedge for the posedge that follows it.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            exp_q.delete();
            m_last_valid = 1'b0;
            m_last_addr  = '0;
            m_cnt        = 0;
            check("rst_valid", o_valid, 0);
            check("rst_addr", o_sram_addr, 0);
            check("rst_lane", o_lane, 0);
            check("rst_oob", o_oob, 0);
            check("rst_reuse", o_reuse, 0);
            check("rst_cnt", o_read_cnt, 0);
        end else begin
            exp_valid = 1'b0;
            exp_reuse = 1'b0;
            if (exp_q.size() > 0) begin
                front     = exp_q[0];
                exp_valid = (front.acc < cyc);
            end
            exp_ready = (exp_q.size() < 2) || i_ready;
            check("ready", o_ready, exp_ready);
            check("valid", o_valid, exp_valid);
            if (exp_valid) begin
                exp_reuse = m_last_valid && !front.oob && (front.addr == m_last_addr);
                check("addr", o_sram_addr, front.addr);
                check("lane", o_lane, front.lane);
                check("oob", o_oob, front.oob);
                check("reuse", o_reuse, exp_reuse);
            end
            check("read_cnt", o_read_cnt, m_cnt);
            out_hs = exp_valid && i_ready;
            in_hs  = i_valid && exp_ready;
            if (i_flush) begin
                m_last_valid = 1'b0;
                m_cnt        = 0;
            end else if (out_hs && !front.oob) begin
                if (!exp_reuse && m_cnt < CNT_MAX) m_cnt++;
                m_last_valid = 1'b1;
                m_last_addr  = front.addr;
            end
            if (out_hs) void'(exp_q.pop_front());
            if (in_hs) exp_q.push_back(modelResult(int'(i_object_id), int'(i_pixel_index), cyc + 1));
        end
        cyc++;
    end

    logic [19:0] col_addr  [40];
    logic        col_reuse [40];
    int          col_cyc   [40];
    int          exp_b2b_addr  [5] = '{3, 3, 3, 3, 4};
    int          exp_b2b_reuse [5] = '{0, 1, 1, 1, 0};
    int          exp_stall_addr[3] = '{25, 50, 75};

    // Entered and left at posedge+1; holds the request until it is accepted.
    task automatic applyStimulus(input logic [3:0] id, input logic [18:0] idx);
        int budget = 0;
        i_valid       = 1'b1;
        i_object_id   = id;
        i_pixel_index = idx;
        @(negedge i_clk);
        while (!o_ready && budget < 50) begin
            @(negedge i_clk);
            budget++;
        end
        if (!o_ready) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept_timeout: got o_ready 0, expected 1 within 50 cycles");
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int ea, input int el, input int eo, input int er);
        int budget = 0;
        @(negedge i_clk);
        while (!o_valid && budget < 10) begin
            @(negedge i_clk);
            budget++;
        end
        check({name, "_valid"}, o_valid, 1);
        if (o_valid) begin
            check({name, "_addr"}, o_sram_addr, ea);
            check({name, "_lane"}, o_lane, el);
            check({name, "_oob"}, o_oob, eo);
            check({name, "_reuse"}, o_reuse, er);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkCount(input string name, input int expected);
        @(negedge i_clk);
        check(name, o_read_cnt, expected);
        @(posedge i_clk);
        #1;
    endtask

    task automatic collectN(input int n);
        int got    = 0;
        int budget = 0;
        while (got < n && budget < 40) begin
            @(negedge i_clk);
            budget++;
            if (o_valid && i_ready) begin
                col_addr[got]  = o_sram_addr;
                col_reuse[got] = o_reuse;
                col_cyc[got]   = budget;
                got++;
            end
        end
        check("collect_count", got, n);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(posedge i_clk);
        #1;
    endtask

    task automatic flushPulse();
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
    endtask

    exp_t pin;

    initial begin
        i_rst_n       = 1'b1;
        i_valid       = 1'b0;
        i_object_id   = OBJECT_MAP;
        i_pixel_index = '0;
        i_ready       = 1'b1;
        i_flush       = 1'b0;

        pin = modelResult(OBJECT_MAP, 13, 0);
        check("pin_model_map13", pin.addr, 3);
        pin = modelResult(OBJECT_SCRATCH, 8, 0);
        check("pin_model_wrap", pin.addr, 1);
        pin = modelResult(OBJECT_MAP, 307200, 0);
        check("pin_model_oob", pin.oob, 1);

        #2;
        i_rst_n = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        applyStimulus(OBJECT_MAP, 19'd13);
        checkOutput("map13", 3, 1, 0, 0);
        checkCount("map13_cnt", 1);

        flushPulse();
        fork
            for (int k = 12; k <= 16; k++) applyStimulus(OBJECT_MAP, 19'(k));
            collectN(5);
        join
        @(posedge i_clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            check("b2b_addr", col_addr[k], exp_b2b_addr[k]);
            check("b2b_reuse", col_reuse[k], exp_b2b_reuse[k]);
            check("b2b_spacing", col_cyc[k], col_cyc[0] + k);
        end
        checkCount("b2b_cnt", 2);

        i_ready = 1'b0;
        fork
            begin
                applyStimulus(OBJECT_MAP, 19'd100);
                applyStimulus(OBJECT_MAP, 19'd200);
                applyStimulus(OBJECT_MAP, 19'd300);
            end
            begin
                for (int k = 0; k < 5; k++) @(negedge i_clk);
                check("stall_ready_low", o_ready, 0);
                check("stall_head_addr", o_sram_addr, 25);
                @(posedge i_clk);
                #1;
                i_ready = 1'b1;
            end
            collectN(3);
        join
        @(posedge i_clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("stall_addr", col_addr[k], exp_stall_addr[k]);
            check("stall_spacing", col_cyc[k], col_cyc[0] + k);
        end
        checkCount("stall_cnt", 5);

        applyStimulus(OBJECT_MAP, 19'd307200);
        checkOutput("oob_size", 0, 0, 1, 0);
        applyStimulus(4'd11, 19'd5);
        checkOutput("oob_id", 0, 0, 1, 0);
        checkCount("oob_cnt", 5);
        applyStimulus(OBJECT_MAP, 19'd301);
        checkOutput("oob_last_kept", 75, 1, 0, 1);
        checkCount("oob_cnt_after", 5);

        applyStimulus(OBJECT_SCRATCH, 19'd8);
        checkOutput("wrap", 1, 0, 0, 0);
        checkCount("wrap_cnt", 6);

        applyStimulus(OBJECT_SCRATCH, 19'd9);
        @(posedge i_clk);
        #1;
        i_flush = 1'b1;
        @(negedge i_clk);
        check("flush_pre_reuse", o_reuse, 1);
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        checkCount("flush_cnt", 0);
        applyStimulus(OBJECT_SCRATCH, 19'd10);
        checkOutput("flush_reuse_cleared", 1, 2, 0, 0);
        checkCount("flush_cnt_after", 1);

        for (int k = 0; k < 36; k++) applyStimulus(OBJECT_MAP, 19'(4 * k));
        idle(4);
        checkCount("sat_cnt", CNT_MAX);

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                #2;
                i_rst_n = 1'b0;
                #1;
                check("async_rst_valid", o_valid, 0);
                check("async_rst_addr", o_sram_addr, 0);
                check("async_rst_lane", o_lane, 0);
                check("async_rst_oob", o_oob, 0);
                check("async_rst_reuse", o_reuse, 0);
                check("async_rst_cnt", o_read_cnt, 0);
                @(posedge i_clk);
                #1;
                i_rst_n = 1'b1;
            end
            i_valid       = ($urandom_range(0, 9) < 7);
            i_object_id   = 4'($urandom_range(0, 15));
            i_pixel_index = ($urandom_range(0, 3) == 0) ? 19'($urandom) : 19'($urandom_range(0, 80));
            i_ready       = ($urandom_range(0, 9) < 7);
            i_flush       = ($urandom_range(0, 99) < 3);
            @(posedge i_clk);
            #1;
        end

        i_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            @(posedge i_clk);
            #1;
        end
        check("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
